// File: rtl/ulpi_pkg.sv
// Shared ULPI definitions: TXCMD prefixes, register-read FSM encodings and TXCMD helper.
package ulpi_pkg;

  localparam logic [1:0] CMD_REG_READ  = 2'b11;
  localparam logic [1:0] CMD_REG_WRITE = 2'b10;

  typedef enum logic [2:0] {
    ULPI_RR_IDLE  = 3'd0,
    ULPI_RR_TXCMD = 3'd1,
    ULPI_RR_TURN  = 3'd2,
    ULPI_RR_DATA  = 3'd3,
    ULPI_RR_WAIT  = 3'd4
  } ulpi_rr_state_e;

  function automatic logic [7:0] reg_read_txcmd(input logic [5:0] addr);
    return {CMD_REG_READ, addr};
  endfunction

endpackage

// File: rtl/ulpi_reg_read_if.sv
// Request side and ULPI bus of the register-read initiator; master = the LINK-side block.
interface ulpi_reg_read_if;
  logic       PrR;
  logic [5:0] ADDR;
  logic       busy;
  logic       done;
  logic [7:0] REG_DATA;
  logic       err;
  logic       DIR;
  logic       NXT;
  logic [7:0] DATA_I;
  logic [7:0] DATA_O;
  logic       DATA_OE;

  modport master (
    input  PrR, ADDR, DIR, NXT, DATA_I,
    output busy, done, REG_DATA, err, DATA_O, DATA_OE
  );

  modport slave (
    output PrR, ADDR, DIR, NXT, DATA_I,
    input  busy, done, REG_DATA, err, DATA_O, DATA_OE
  );
endinterface

// File: rtl/ulpi_timeout_cnt.sv
// Per-attempt cycle counter: load clears, en counts, expire flags the LIMIT-th counted cycle.
module ulpi_timeout_cnt #(
  parameter int LIMIT = 255,
  parameter int W     = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  input  logic en_i,
  output logic expire_o
);

  logic [W-1:0] cnt_q;

  // cycle counter, load has priority over counting
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= {W{1'b0}};
    end else if (load_i) begin
      cnt_q <= {W{1'b0}};
    end else if (en_i) begin
      cnt_q <= cnt_q + {{(W-1){1'b0}}, 1'b1};
    end else begin
      cnt_q <= cnt_q;
    end
  end

  assign expire_o = en_i && (cnt_q == W'(LIMIT - 1));

endmodule

// File: rtl/ulpi_reg_read.sv
// ULPI immediate register read initiator (LINK side) with automatic retry on PHY abort.
// Optional per-attempt timeout enabled by defining ULPI_RR_TIMEOUT_EN.
module ulpi_reg_read
  import ulpi_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TO_W           = 8
) (
  input  logic              clk_ULPI,
  input  logic              rst,
  ulpi_reg_read_if.master   bus
);

  if ((2 ** TO_W) <= TIMEOUT_CYCLES) begin : g_bad_to_w
    $error("TO_W too narrow for TIMEOUT_CYCLES");
  end

  ulpi_rr_state_e state_q, state_d;
  logic [5:0]     addr_q, addr_d;
  logic [7:0]     reg_data_q, reg_data_d;
  logic [7:0]     data_o_q, data_o_d;
  logic           data_oe_q, data_oe_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           err_q, err_d;
  logic           expire_s;

`ifdef ULPI_RR_TIMEOUT_EN
  logic load_s;
  logic cnt_en_s;

  // a fresh attempt starts on every request accept and every (re)entry to TXCMD
  assign cnt_en_s = (state_q != ULPI_RR_IDLE);
  assign load_s   = ((state_d == ULPI_RR_TXCMD) && (state_q != ULPI_RR_TXCMD)) ||
                    (state_q == ULPI_RR_IDLE);

  ulpi_timeout_cnt #(
    .LIMIT (TIMEOUT_CYCLES),
    .W     (TO_W)
  ) u_timeout_cnt (
    .clk      (clk_ULPI),
    .rst      (rst),
    .load_i   (load_s),
    .en_i     (cnt_en_s),
    .expire_o (expire_s)
  );
`else
  assign expire_s = 1'b0;
`endif

  // next-state and registered-output computation
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    reg_data_d = reg_data_q;
    done_d     = 1'b0;
    err_d      = 1'b0;

    case (state_q)
      ULPI_RR_IDLE: begin
        if (bus.PrR) begin
          addr_d  = bus.ADDR;
          state_d = bus.DIR ? ULPI_RR_WAIT : ULPI_RR_TXCMD;
        end else begin
          state_d = ULPI_RR_IDLE;
        end
      end
      ULPI_RR_WAIT: begin
        if (bus.DIR) begin
          state_d = ULPI_RR_WAIT;
        end else begin
          state_d = ULPI_RR_TXCMD;
        end
      end
      ULPI_RR_TXCMD: begin
        // DIR wins over NXT: any PHY takeover aborts the command
        if (bus.DIR) begin
          state_d = ULPI_RR_WAIT;
        end else if (bus.NXT) begin
          state_d = ULPI_RR_TURN;
        end else begin
          state_d = ULPI_RR_TXCMD;
        end
      end
      ULPI_RR_TURN: begin
        if (bus.DIR) begin
          state_d = ULPI_RR_DATA;
        end else begin
          state_d = ULPI_RR_TURN;
        end
      end
      ULPI_RR_DATA: begin
        if (bus.DIR && !bus.NXT) begin
          reg_data_d = bus.DATA_I;
          done_d     = 1'b1;
          state_d    = ULPI_RR_IDLE;
        end else if (bus.DIR) begin
          state_d = ULPI_RR_WAIT;
        end else begin
          state_d = ULPI_RR_TXCMD;
        end
      end
      default: begin
        state_d = ULPI_RR_IDLE;
      end
    endcase

    if (expire_s) begin
      state_d    = ULPI_RR_IDLE;
      reg_data_d = reg_data_q;
      done_d     = 1'b0;
      err_d      = 1'b1;
    end else begin
      err_d = 1'b0;
    end

    data_oe_d = (state_d == ULPI_RR_TXCMD);
    data_o_d  = data_oe_d ? reg_read_txcmd(addr_d) : 8'h00;
    busy_d    = (state_d != ULPI_RR_IDLE);
  end

  // state and output registers
  always_ff @(posedge clk_ULPI or posedge rst) begin
    if (rst) begin
      state_q    <= ULPI_RR_IDLE;
      addr_q     <= 6'h00;
      reg_data_q <= 8'h00;
      data_o_q   <= 8'h00;
      data_oe_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      reg_data_q <= reg_data_d;
      data_o_q   <= data_o_d;
      data_oe_q  <= data_oe_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign bus.DATA_O   = data_o_q;
  assign bus.DATA_OE  = data_oe_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.REG_DATA = reg_data_q;
  assign bus.err      = err_q;

endmodule
